// File: rtl/sel_seq.sv
// Sequencing slice selector: captures a W-bit vector and streams a run of its
// N equal-width slices, one per beat, starting at a given index and wrapping.
module sel_seq #(
    parameter  int W     = 32,
    parameter  int N     = 4,
    localparam int OUT_W = W / N,
    localparam int IDX_W = $clog2(N),
    localparam int CNT_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             i_in_vld,
    input  logic [W-1:0]     i_in_x,
    input  logic [IDX_W-1:0] i_in_start,
    input  logic [CNT_W-1:0] i_in_cnt,
    output logic             o_in_rdy,
    output logic             o_out_vld,
    output logic [OUT_W-1:0] o_out_y,
    output logic [IDX_W-1:0] o_out_idx,
    output logic             o_out_last,
    input  logic             i_out_rdy
);

    generate
        if (N < 2 || (W % N) != 0) begin : g_bad_params
            $error("sel_seq: N must be >= 2 and divide W");
        end
    endgenerate

    typedef enum logic {IDLE, EMIT} state_t;

    state_t           state;
    logic [W-1:0]     x_q;
    logic [CNT_W-1:0] rem_q;

    logic             accept;
    logic             beat_hs;
    logic [IDX_W-1:0] start_c;
    logic [CNT_W-1:0] cnt_c;
    logic [IDX_W:0]   start_ext;
    logic [IDX_W-1:0] idx_next;

    function automatic logic [OUT_W-1:0] slice_of(input logic [W-1:0] v,
                                                  input logic [IDX_W-1:0] k);
        slice_of = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (k == IDX_W'(i)) slice_of = v[OUT_W*i +: OUT_W];
        end
    endfunction

    // Chaining term lets the next command land in the cycle the last beat leaves.
    assign o_in_rdy = !arst & ((state == IDLE) | (o_out_vld & i_out_rdy & o_out_last));
    assign accept   = i_in_vld & o_in_rdy;
    assign beat_hs  = o_out_vld & i_out_rdy;

    // IDX_W = clog2(N) means start < 2N, so one conditional subtract is a full modulo.
    assign start_ext = {1'b0, i_in_start};
    assign start_c   = (start_ext >= (IDX_W+1)'(N)) ? IDX_W'(start_ext - (IDX_W+1)'(N))
                                                    : i_in_start;
    assign cnt_c     = (i_in_cnt > CNT_W'(N)) ? CNT_W'(N) : i_in_cnt;
    assign idx_next  = (o_out_idx == IDX_W'(N - 1)) ? '0 : o_out_idx + IDX_W'(1);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state      <= IDLE;
            x_q        <= '0;
            rem_q      <= '0;
            o_out_vld  <= 1'b0;
            o_out_y    <= '0;
            o_out_idx  <= '0;
            o_out_last <= 1'b0;
        end else if (accept) begin
            x_q <= i_in_x;
            if (cnt_c != '0) begin
                state      <= EMIT;
                rem_q      <= cnt_c;
                o_out_vld  <= 1'b1;
                o_out_idx  <= start_c;
                o_out_y    <= slice_of(i_in_x, start_c);
                o_out_last <= (cnt_c == CNT_W'(1));
            end else begin
                state      <= IDLE;
                rem_q      <= '0;
                o_out_vld  <= 1'b0;
                o_out_last <= 1'b0;
            end
        end else if (beat_hs) begin
            if (o_out_last) begin
                state      <= IDLE;
                rem_q      <= '0;
                o_out_vld  <= 1'b0;
                o_out_last <= 1'b0;
            end else begin
                rem_q      <= rem_q - CNT_W'(1);
                o_out_idx  <= idx_next;
                o_out_y    <= slice_of(x_q, idx_next);
                o_out_last <= (rem_q == CNT_W'(2));
            end
        end
    end

endmodule

// File: tb/tb_sel_seq.sv
// Directed bench for sel_seq: one N=4 instance (W=32) and one N=3 instance (W=24)
// checked against hand-computed beat sequences.
module tb_sel_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic arst;
    int   tests = 0;
    int   fails = 0;

    // N=4, W=32 instance
    logic        a_vld;
    logic [31:0] a_x;
    logic [1:0]  a_start;
    logic [2:0]  a_cnt;
    logic        a_in_rdy;
    logic        a_ovld;
    logic [7:0]  a_y;
    logic [1:0]  a_idx;
    logic        a_last;
    logic        a_ordy;

    // N=3, W=24 instance
    logic        b_vld;
    logic [23:0] b_x;
    logic [1:0]  b_start;
    logic [1:0]  b_cnt;
    logic        b_in_rdy;
    logic        b_ovld;
    logic [7:0]  b_y;
    logic [1:0]  b_idx;
    logic        b_last;
    logic        b_ordy;

    sel_seq #(.W(32), .N(4)) u4 (
        .clk(clk), .arst(arst),
        .i_in_vld(a_vld), .i_in_x(a_x), .i_in_start(a_start), .i_in_cnt(a_cnt),
        .o_in_rdy(a_in_rdy), .o_out_vld(a_ovld), .o_out_y(a_y), .o_out_idx(a_idx),
        .o_out_last(a_last), .i_out_rdy(a_ordy)
    );

    sel_seq #(.W(24), .N(3)) u3 (
        .clk(clk), .arst(arst),
        .i_in_vld(b_vld), .i_in_x(b_x), .i_in_start(b_start), .i_in_cnt(b_cnt),
        .o_in_rdy(b_in_rdy), .o_out_vld(b_ovld), .o_out_y(b_y), .o_out_idx(b_idx),
        .o_out_last(b_last), .i_out_rdy(b_ordy)
    );

    // Packed view {vld, y, idx, last, in_rdy} for single-line comparisons.
    wire [12:0] a_obs = {a_ovld, a_y, a_idx, a_last, a_in_rdy};
    wire [12:0] b_obs = {b_ovld, b_y, b_idx, b_last, b_in_rdy};

    task automatic test_reset();
        arst = 1'b1;
        a_vld = 1'b0; a_x = '0; a_start = '0; a_cnt = '0; a_ordy = 1'b1;
        b_vld = 1'b0; b_x = '0; b_start = '0; b_cnt = '0; b_ordy = 1'b1;
        repeat (2) @(negedge clk);
        tests++;
        if (a_obs !== 13'h0) begin
            fails++; $display("FAIL reset_n4 got=%h exp=%h", a_obs, 13'h0);
        end
        tests++;
        if (b_obs !== 13'h0) begin
            fails++; $display("FAIL reset_n3 got=%h exp=%h", b_obs, 13'h0);
        end
        arst = 1'b0;
        #1;
        tests++;
        if ({a_in_rdy, b_in_rdy, a_ovld, b_ovld} !== 4'b1100) begin
            fails++;
            $display("FAIL reset_release got=%b exp=%b", {a_in_rdy, b_in_rdy, a_ovld, b_ovld}, 4'b1100);
        end
    endtask

    task automatic test_basic();
        logic [7:0] ey [4];
        ey = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(negedge clk);
        a_x = 32'hDDCCBBAA; a_start = 2'd0; a_cnt = 3'd4; a_vld = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (a_obs !== {1'b1, ey[k], 2'(k), k == 3, k == 3}) begin
                fails++;
                $display("FAIL basic_beat%0d got=%h exp=%h", k, a_obs, {1'b1, ey[k], 2'(k), k == 3, k == 3});
            end
            @(negedge clk);
        end
        tests++;
        if ({a_ovld, a_in_rdy} !== 2'b01) begin
            fails++; $display("FAIL basic_idle got=%b exp=%b", {a_ovld, a_in_rdy}, 2'b01);
        end
    endtask

    task automatic test_wrap();
        a_x = 32'hDDCCBBAA; a_start = 2'd3; a_cnt = 3'd2; a_vld = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        tests++;
        if (a_obs !== {1'b1, 8'hDD, 2'd3, 1'b0, 1'b0}) begin
            fails++; $display("FAIL wrap_beat0 got=%h exp=%h", a_obs, {1'b1, 8'hDD, 2'd3, 1'b0, 1'b0});
        end
        @(negedge clk);
        tests++;
        if (a_obs !== {1'b1, 8'hAA, 2'd0, 1'b1, 1'b1}) begin
            fails++; $display("FAIL wrap_beat1 got=%h exp=%h", a_obs, {1'b1, 8'hAA, 2'd0, 1'b1, 1'b1});
        end
        @(negedge clk);
        tests++;
        if (a_ovld !== 1'b0) begin
            fails++; $display("FAIL wrap_end got=%b exp=%b", a_ovld, 1'b0);
        end
    endtask

    task automatic test_n3_wrap();
        logic [7:0] ey [3];
        logic [1:0] ei [3];
        ey = '{8'h33, 8'h11, 8'h22};
        ei = '{2'd2, 2'd0, 2'd1};
        b_x = 24'h332211; b_start = 2'd2; b_cnt = 2'd3; b_vld = 1'b1; b_ordy = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (b_obs !== {1'b1, ey[k], ei[k], k == 2, k == 2}) begin
                fails++;
                $display("FAIL n3_beat%0d got=%h exp=%h", k, b_obs, {1'b1, ey[k], ei[k], k == 2, k == 2});
            end
            @(negedge clk);
        end
        tests++;
        if (b_ovld !== 1'b0) begin
            fails++; $display("FAIL n3_end got=%b exp=%b", b_ovld, 1'b0);
        end
    endtask

    task automatic test_clamp_mod();
        logic [7:0] ey [4];
        logic [1:0] ei [4];
        ey = '{8'hCC, 8'hDD, 8'hAA, 8'hBB};
        ei = '{2'd2, 2'd3, 2'd0, 2'd1};
        // cnt=7 on N=4 clamps to a 4-beat run
        a_x = 32'hDDCCBBAA; a_start = 2'd2; a_cnt = 3'd7; a_vld = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (a_obs !== {1'b1, ey[k], ei[k], k == 3, k == 3}) begin
                fails++;
                $display("FAIL clamp_beat%0d got=%h exp=%h", k, a_obs, {1'b1, ey[k], ei[k], k == 3, k == 3});
            end
            @(negedge clk);
        end
        tests++;
        if (a_ovld !== 1'b0) begin
            fails++; $display("FAIL clamp_end got=%b exp=%b", a_ovld, 1'b0);
        end
        // start=3 on N=3 reduces to slice 0
        b_x = 24'h332211; b_start = 2'd3; b_cnt = 2'd1; b_vld = 1'b1;
        @(negedge clk);
        b_vld = 1'b0;
        tests++;
        if (b_obs !== {1'b1, 8'h11, 2'd0, 1'b1, 1'b1}) begin
            fails++; $display("FAIL mod_start got=%h exp=%h", b_obs, {1'b1, 8'h11, 2'd0, 1'b1, 1'b1});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic       rdy_seq [6];
        logic [7:0] ey [3];
        int         beat;
        int         hs;
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        ey = '{8'hBB, 8'hCC, 8'hDD};
        beat = 0;
        hs = 0;
        a_x = 32'hDDCCBBAA; a_start = 2'd1; a_cnt = 3'd3; a_vld = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        for (int c = 0; c < 6; c++) begin
            a_ordy = rdy_seq[c];
            #1;
            tests++;
            if (a_obs !== {1'b1, ey[beat], 2'(beat + 1), beat == 2, (beat == 2) && rdy_seq[c]}) begin
                fails++;
                $display("FAIL bp_cycle%0d got=%h exp=%h", c, a_obs,
                         {1'b1, ey[beat], 2'(beat + 1), beat == 2, (beat == 2) && rdy_seq[c]});
            end
            if (a_ovld && a_ordy) hs++;
            if (rdy_seq[c]) beat++;
            @(negedge clk);
        end
        a_ordy = 1'b1;
        tests++;
        if ({a_ovld, 32'(hs)} !== {1'b0, 32'd3}) begin
            fails++; $display("FAIL bp_handshakes got=%0d vld=%b exp=3 vld=0", hs, a_ovld);
        end
    endtask

    task automatic test_back_to_back();
        a_x = 32'hDDCCBBAA; a_start = 2'd0; a_cnt = 3'd2; a_vld = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        tests++;
        if (a_obs !== {1'b1, 8'hAA, 2'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL b2b_a0 got=%h exp=%h", a_obs, {1'b1, 8'hAA, 2'd0, 1'b0, 1'b0});
        end
        @(negedge clk);
        a_start = 2'd2; a_cnt = 3'd1; a_vld = 1'b1;
        tests++;
        if (a_obs !== {1'b1, 8'hBB, 2'd1, 1'b1, 1'b1}) begin
            fails++; $display("FAIL b2b_a1 got=%h exp=%h", a_obs, {1'b1, 8'hBB, 2'd1, 1'b1, 1'b1});
        end
        @(negedge clk);
        // zero-length command offered on B's last beat
        a_cnt = 3'd0; a_vld = 1'b1;
        tests++;
        if (a_obs !== {1'b1, 8'hCC, 2'd2, 1'b1, 1'b1}) begin
            fails++; $display("FAIL b2b_b0 got=%h exp=%h", a_obs, {1'b1, 8'hCC, 2'd2, 1'b1, 1'b1});
        end
        @(negedge clk);
        tests++;
        if ({a_ovld, a_in_rdy} !== 2'b01) begin
            fails++; $display("FAIL b2b_zero_on_last got=%b exp=%b", {a_ovld, a_in_rdy}, 2'b01);
        end
        @(negedge clk);
        a_vld = 1'b0;
        tests++;
        if ({a_ovld, a_in_rdy} !== 2'b01) begin
            fails++; $display("FAIL b2b_zero_idle got=%b exp=%b", {a_ovld, a_in_rdy}, 2'b01);
        end
    endtask

    task automatic test_arst_midrun();
        a_x = 32'hDDCCBBAA; a_start = 2'd1; a_cnt = 3'd4; a_vld = 1'b1; a_ordy = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (a_obs !== {1'b1, 8'hDD, 2'd3, 1'b0, 1'b0}) begin
            fails++; $display("FAIL arst_beat2 got=%h exp=%h", a_obs, {1'b1, 8'hDD, 2'd3, 1'b0, 1'b0});
        end
        #1 arst = 1'b1;
        #1;
        tests++;
        if (a_obs !== 13'h0) begin
            fails++; $display("FAIL arst_async got=%h exp=%h", a_obs, 13'h0);
        end
        @(negedge clk);
        arst = 1'b0;
        #1;
        tests++;
        if ({a_ovld, a_in_rdy} !== 2'b01) begin
            fails++; $display("FAIL arst_release got=%b exp=%b", {a_ovld, a_in_rdy}, 2'b01);
        end
        a_start = 2'd2; a_cnt = 3'd1; a_vld = 1'b1;
        @(negedge clk);
        a_vld = 1'b0;
        tests++;
        if (a_obs !== {1'b1, 8'hCC, 2'd2, 1'b1, 1'b1}) begin
            fails++; $display("FAIL arst_restart got=%h exp=%h", a_obs, {1'b1, 8'hCC, 2'd2, 1'b1, 1'b1});
        end
        @(negedge clk);
        tests++;
        if (a_ovld !== 1'b0) begin
            fails++; $display("FAIL arst_restart_end got=%b exp=%b", a_ovld, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_n3_wrap();
        test_clamp_mod();
        test_backpressure();
        test_back_to_back();
        test_arst_midrun();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
